// File: rtl/ticket_dispatcher_pkg.sv
// Shared types and default sizing for the ticket dispatcher.
// Holds the shop-state enum used by the top-level sequencer.
package ticket_pkg;

  localparam int NUM_DESKS_DEF   = 4;
  localparam int MAX_CLIENTS_DEF = 100;
  localparam int CNT_W_DEF       = 8;

  typedef enum logic [1:0] {
    OPEN   = 2'd0,
    FULL   = 2'd1,
    CLOSED = 2'd2
  } state_t;

endpackage

// File: rtl/ticket_dispatcher_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found
// searching upward from ptr+1 with wrap-around.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  int cand;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/ticket_dispatcher.sv
// Shared ticket queue feeding NUM_DESKS service desks with round-robin dispatch.
// Define BTN_EDGE_DETECT_EN to accept raw button levels (rising-edge events, +1 cycle).
module ticket_dispatcher
  import ticket_pkg::*;
#(
  parameter int NUM_DESKS   = NUM_DESKS_DEF,
  parameter int MAX_CLIENTS = MAX_CLIENTS_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       new_req,
  input  logic [NUM_DESKS-1:0]       desk_done,
  output logic                       new_ack,
  output logic                       new_rej,
  output logic [CNT_W-1:0]           issued_count,
  output logic [CNT_W-1:0]           served_count,
  output logic [CNT_W-1:0]           waiting,
  output logic [NUM_DESKS-1:0]       desk_busy,
  output logic [NUM_DESKS*CNT_W-1:0] desk_ticket,
  output logic                       full,
  output logic                       closed,
  output logic                       done_err
);

  localparam int PTR_W = $clog2(NUM_DESKS);

  logic                 new_ev;
  logic [NUM_DESKS-1:0] done_ev;

`ifdef BTN_EDGE_DETECT_EN
  logic                 new_lvl_q, new_lvl_d, new_ev_q, new_ev_d;
  logic [NUM_DESKS-1:0] done_lvl_q, done_lvl_d, done_ev_q, done_ev_d;

  always_comb begin
    new_lvl_d  = new_req;
    done_lvl_d = desk_done;
    new_ev_d   = new_req & ~new_lvl_q;
    done_ev_d  = desk_done & ~done_lvl_q;
  end

  // Level history presets high so a button already held at reset release is not an event.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      new_lvl_q  <= 1'b1;
      done_lvl_q <= '1;
      new_ev_q   <= 1'b0;
      done_ev_q  <= '0;
    end else begin
      new_lvl_q  <= new_lvl_d;
      done_lvl_q <= done_lvl_d;
      new_ev_q   <= new_ev_d;
      done_ev_q  <= done_ev_d;
    end
  end

  assign new_ev  = new_ev_q;
  assign done_ev = done_ev_q;
`else
  assign new_ev  = new_req;
  assign done_ev = desk_done;
`endif

  logic [CNT_W-1:0]     issued_q, issued_d, served_q, served_d, waiting_q, waiting_d;
  logic [NUM_DESKS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]     ticket_q [NUM_DESKS];
  logic [CNT_W-1:0]     ticket_d [NUM_DESKS];
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  state_t               state_q, state_d;
  logic                 ack_q, ack_d, rej_q, rej_d, err_q, err_d;

  logic [NUM_DESKS-1:0] accepted, arb_req, grant;
  logic [PTR_W-1:0]     grant_idx;
  logic                 grant_valid;
  logic [CNT_W-1:0]     next_ticket;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_DESKS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_DESKS; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // A desk finishing this cycle is not offered for dispatch until the next one.
  assign arb_req = (waiting_q != '0) ? (~busy_q & ~done_ev) : '0;

  rr_arbiter #(.N(NUM_DESKS), .IDX_W(PTR_W)) u_arb (
    .req         (arb_req),
    .ptr         (ptr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    accepted    = done_ev & busy_q;
    next_ticket = issued_q - waiting_q + CNT_W'(1);
    issued_d    = issued_q;
    ack_d       = 1'b0;
    rej_d       = 1'b0;
    if (new_ev) begin
      if (issued_q < CNT_W'(MAX_CLIENTS)) begin
        issued_d = issued_q + CNT_W'(1);
        ack_d    = 1'b1;
      end else begin
        rej_d = 1'b1;
      end
    end
    waiting_d = waiting_q + CNT_W'(ack_d) - CNT_W'(grant_valid);
    served_d  = served_q + popcount(accepted);
    busy_d    = (busy_q & ~accepted) | grant;
    ticket_d  = ticket_q;
    ptr_d     = ptr_q;
    if (grant_valid) begin
      ticket_d[grant_idx] = next_ticket;
      ptr_d               = grant_idx;
    end
    err_d   = err_q | (|(done_ev & ~busy_q));
    state_d = state_q;
    case (state_q)
      OPEN:    if (issued_d == CNT_W'(MAX_CLIENTS)) state_d = FULL;
      FULL:    if (waiting_d == '0 && busy_d == '0) state_d = CLOSED;
      default: state_d = state_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      issued_q  <= '0;
      served_q  <= '0;
      waiting_q <= '0;
      busy_q    <= '0;
      for (int i = 0; i < NUM_DESKS; i++) ticket_q[i] <= '0;
      ptr_q     <= PTR_W'(NUM_DESKS - 1);
      state_q   <= OPEN;
      ack_q     <= 1'b0;
      rej_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      issued_q  <= issued_d;
      served_q  <= served_d;
      waiting_q <= waiting_d;
      busy_q    <= busy_d;
      ticket_q  <= ticket_d;
      ptr_q     <= ptr_d;
      state_q   <= state_d;
      ack_q     <= ack_d;
      rej_q     <= rej_d;
      err_q     <= err_d;
    end
  end

  for (genvar g = 0; g < NUM_DESKS; g++) begin : g_ticket
    assign desk_ticket[g*CNT_W +: CNT_W] = ticket_q[g];
  end

  assign new_ack      = ack_q;
  assign new_rej      = rej_q;
  assign issued_count = issued_q;
  assign served_count = served_q;
  assign waiting      = waiting_q;
  assign desk_busy    = busy_q;
  assign full         = (state_q != OPEN);
  assign closed       = (state_q == CLOSED);
  assign done_err     = err_q;

endmodule

// File: tb/tb_ticket_dispatcher.sv
// Scoreboard bench for ticket_dispatcher: a queue-based reference model predicts
// every cycle's outputs and every dispatch; a monitor compares them after each edge.
module tb_ticket_dispatcher;
  import ticket_pkg::*;

  localparam int N    = 4;
  localparam int MAXC = 100;
  localparam int W    = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1, clr = 1'b0, new_req = 1'b0;
  logic [N-1:0]   desk_done = '0;
  logic           new_ack, new_rej, full, closed, done_err;
  logic [W-1:0]   issued_count, served_count, waiting;
  logic [N-1:0]   desk_busy;
  logic [N*W-1:0] desk_ticket;

  ticket_dispatcher #(.NUM_DESKS(N), .MAX_CLIENTS(MAXC), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .clr(clr), .new_req(new_req), .desk_done(desk_done),
    .new_ack(new_ack), .new_rej(new_rej), .issued_count(issued_count),
    .served_count(served_count), .waiting(waiting), .desk_busy(desk_busy),
    .desk_ticket(desk_ticket), .full(full), .closed(closed), .done_err(done_err)
  );

  typedef struct packed {
    logic         ack, rej;
    logic [W-1:0] issued, served, waiting;
    logic [N-1:0] busy;
    logic [N*W-1:0] tkt;
    logic         full, closed, err;
  } snap_t;

  typedef struct packed {
    logic [7:0]   desk;
    logic [W-1:0] tkt;
  } disp_t;

  snap_t snap_q[$];
  disp_t disp_q[$];
  int checks = 0, errors = 0;

  // Reference model: tickets live in a FIFO of numbers, desks in plain arrays.
  int m_issued, m_served, m_ptr, m_rejs;
  int m_wait_q[$];
  bit m_busy[N];
  int m_tkt[N];
  bit m_err, m_ack, m_rej;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_idle();
    for (int i = 0; i < N; i++) if (m_busy[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input bit r, input bit c, input bit nr, input bit [N-1:0] dn);
    int    g;
    disp_t d;
    g     = -1;
    m_ack = 1'b0;
    m_rej = 1'b0;
    if (r || c) begin
      m_issued = 0;
      m_served = 0;
      m_wait_q.delete();
      for (int i = 0; i < N; i++) begin
        m_busy[i] = 1'b0;
        m_tkt[i]  = 0;
      end
      m_ptr = N - 1;
      m_err = 1'b0;
      return;
    end
    if (m_wait_q.size() > 0)
      for (int k = 1; k <= N; k++) begin
        int cand;
        cand = (m_ptr + k) % N;
        if (g < 0 && !m_busy[cand] && !dn[cand]) g = cand;
      end
    for (int i = 0; i < N; i++)
      if (dn[i]) begin
        if (m_busy[i]) begin
          m_busy[i] = 1'b0;
          m_served++;
        end else begin
          m_err = 1'b1;
        end
      end
    if (g >= 0) begin
      m_busy[g] = 1'b1;
      m_tkt[g]  = m_wait_q.pop_front();
      m_ptr     = g;
      d.desk    = 8'(g);
      d.tkt     = W'(m_tkt[g]);
      disp_q.push_back(d);
    end
    if (nr) begin
      if (m_issued < MAXC) begin
        m_issued++;
        m_wait_q.push_back(m_issued);
        m_ack = 1'b1;
      end else begin
        m_rej = 1'b1;
        m_rejs++;
      end
    end
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.ack     = m_ack;
    s.rej     = m_rej;
    s.issued  = W'(m_issued);
    s.served  = W'(m_served);
    s.waiting = W'(m_wait_q.size());
    s.tkt     = '0;
    for (int i = 0; i < N; i++) begin
      s.busy[i]          = m_busy[i];
      s.tkt[i*W +: W]    = W'(m_tkt[i]);
    end
    s.full   = (m_issued == MAXC);
    s.closed = s.full && m_wait_q.size() == 0 && model_idle();
    s.err    = m_err;
    return s;
  endfunction

  task automatic drive(input bit r, input bit c, input bit nr, input bit [N-1:0] dn);
    @(negedge clk);
    rst       = r;
    clr       = c;
    new_req   = nr;
    desk_done = dn;
    model_step(r, c, nr, dn);
    snap_q.push_back(model_snap());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0);
  endtask

  function automatic bit [N-1:0] rand_done(input int pct);
    bit [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      if (m_busy[i] && int'($urandom_range(0, 99)) < pct) v[i] = 1'b1;
    return v;
  endfunction

  // Monitor: one expected snapshot per edge, plus a dispatch record per busy rise.
  snap_t      mon_s;
  disp_t      mon_d;
  logic [N-1:0] prev_busy = '0;

  always @(posedge clk) begin
    #1;
    if (snap_q.size() > 0) begin
      mon_s = snap_q.pop_front();
      check("new_ack",      new_ack,      mon_s.ack);
      check("new_rej",      new_rej,      mon_s.rej);
      check("issued_count", issued_count, mon_s.issued);
      check("served_count", served_count, mon_s.served);
      check("waiting",      waiting,      mon_s.waiting);
      check("desk_busy",    desk_busy,    mon_s.busy);
      check("desk_ticket",  desk_ticket,  mon_s.tkt);
      check("full",         full,         mon_s.full);
      check("closed",       closed,       mon_s.closed);
      check("done_err",     done_err,     mon_s.err);
    end
    for (int i = 0; i < N; i++)
      if (desk_busy[i] === 1'b1 && prev_busy[i] === 1'b0) begin
        if (disp_q.size() == 0) begin
          check("unexpected_dispatch_desk", 64'(i), 64'hFF);
        end else begin
          mon_d = disp_q.pop_front();
          check("dispatch_desk",   64'(i), 64'(mon_d.desk));
          check("dispatch_ticket", desk_ticket[i*W +: W], mon_d.tkt);
        end
      end
    prev_busy = desk_busy;
  end

  initial begin
    int cyc;
    m_rejs = 0;
    drive(1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b1, '1);

    // Three tickets go to desks 0,1,2; then two more fill desk 3 and leave one waiting.
    repeat (3) drive(1'b0, 1'b0, 1'b1, '0);
    idle(3);
    repeat (2) drive(1'b0, 1'b0, 1'b1, '0);
    idle(2);
    drive(1'b0, 1'b0, 1'b0, 4'b0100);
    idle(2);
    // Two waiting tickets, two desks finish together.
    repeat (2) drive(1'b0, 1'b0, 1'b1, '0);
    drive(1'b0, 1'b0, 1'b0, 4'b0011);
    idle(3);

    // Random traffic until the day fills and a few requests are refused.
    cyc = 0;
    while (m_rejs < 3 && cyc < 3000) begin
      drive(1'b0, 1'b0, ($urandom_range(0, 99) < 60), rand_done(30));
      cyc++;
    end
    idle(1);
    @(posedge clk); #2;
    check("full_lamp", full, 1'b1);

    // Drain every desk until the shop closes.
    cyc = 0;
    while (!(m_wait_q.size() == 0 && model_idle()) && cyc < 2000) begin
      drive(1'b0, 1'b0, ($urandom_range(0, 99) < 20), rand_done(40));
      cyc++;
    end
    idle(1);
    @(posedge clk); #2;
    check("closed_lamp", closed, 1'b1);

    drive(1'b0, 1'b0, 1'b1, '0);
    drive(1'b0, 1'b0, 1'b0, 4'b1000);
    idle(1);
    drive(1'b0, 1'b1, 1'b1, '1);
    idle(2);

    // Mixed random traffic with stray dones and occasional mid-service clears.
    for (int i = 0; i < 300; i++) begin
      bit [N-1:0] dn;
      dn = rand_done(35);
      if ($urandom_range(0, 99) < 3) dn[$urandom_range(0, N-1)] = 1'b1;
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 2),
            ($urandom_range(0, 99) < 50), dn);
    end
    idle(2);
    @(posedge clk); #2;
    check("snapshots_drained", 64'(snap_q.size()), 64'd0);
    check("dispatches_drained", 64'(disp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
